// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops registered at the accept edge, plus an
// iterative shift-add multiply that stalls the issue side while it runs.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_LUI  = 4'b0110,
    OP_SLL  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_MUL  = 4'b1011
  } op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW:0]     cnt_q;

  logic             out_free;
  logic             accept;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_ovf_d;
  logic [WIDTH-1:0] acc_d;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = !rst && (state_q == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  assign sum   = data1 + data2;
  assign diff  = data1 - data2;
  assign shamt = data1[SHW-1:0];
  assign acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;

  // NOTE: every output of an always_comb gets a default before the case,
  // otherwise an undecoded opcode would infer a latch.
  always_comb begin
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (aluop)
      OP_ADD: begin
        alu_res_d = sum;
        alu_ovf_d = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                    (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_d = diff;
        alu_ovf_d = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                    (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_AND:  alu_res_d = data1 & data2;
      OP_OR:   alu_res_d = data1 | data2;
      OP_XOR:  alu_res_d = data1 ^ data2;
      // Compare directly rather than via diff's sign so overflow cannot flip it.
      OP_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_LUI:  alu_res_d = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_res_d = data2 << shamt;
      OP_SRL:  alu_res_d = data2 >> shamt;
      OP_SRA:  alu_res_d = $unsigned($signed(data2) >>> shamt);
      OP_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      default: begin
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
      end
    endcase
  end

  // NOTE: multiplier datapath registers are left out of reset; they are always
  // loaded on entry to MUL and nothing observes them in IDLE.
  // NOTE: non-blocking assignments throughout, so a later assignment in the
  // same edge (loading a new result) overrides the handoff clear above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (aluop == OP_MUL) begin
              state_q  <= MUL;
              mcand_q  <= data1;
              mplier_q <= data2;
              acc_q    <= '0;
              cnt_q    <= CNT_FULL;
            end else begin
              result_q    <= alu_res_d;
              ovf_q       <= alu_ovf_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL: begin
          if (cnt_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_ONE;
          end
          // Finish on the last step if the output is free, else park at count 0.
          if (out_free && (cnt_q == CNT_ONE || cnt_q == '0)) begin
            result_q    <= (cnt_q == '0) ? acc_q : acc_d;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == MUL);

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU for the MIPS datapath running the AES workload. It keeps the existing 4-bit opcode map and adds arithmetic shift right, unsigned compare and an iterative multiply. Every result is registered. Operands enter and results leave through valid/ready handshakes, so the block can stall the issue stage during multi-cycle operations.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64
- SHW, $clog2(WIDTH), derived shift-amount width; not overridden
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand/opcode valid
- in_ready  out  1  block accepts operands this cycle
- aluop  in  4  opcode
- data1  in  WIDTH  operand 1 (shift amount for shift ops)
- data2  in  WIDTH  operand 2 (value shifted for shift ops)
- out_valid  out  1  result/overflow valid
- out_ready  in  1  consumer takes result this cycle
- result  out  WIDTH  registered result
- overflow  out  1  registered signed overflow flag
- busy  out  1  multiply in progress

## Operation
- Accept: in_valid & in_ready at a rising edge. Operands and opcode are captured at that edge.
- Result handoff: out_valid & out_ready at a rising edge.
- Opcodes; all arithmetic is modulo 2^WIDTH:
  - 0000 add: data1+data2
  - 0001 sub: data1-data2
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt: {0…,1} if signed data1 < signed data2, else 0. This is a true signed compare, correct even when the subtraction overflows.
  - 0110 lui: {data2[WIDTH/2-1:0], WIDTH/2 zeros}
  - 0111 sll: data2 << data1[SHW-1:0]
  - 1000 srl: data2 >> data1[SHW-1:0], zero fill
  - 1001 sra: data2 >>> data1[SHW-1:0], sign fill
  - 1010 sltu: unsigned compare, same result format as slt
  - 1011 mul: low WIDTH bits of data1*data2; signed and unsigned give identical low bits
  - 1100–1111: result 0, overflow 0
- overflow:
  - add: set when both operands have the same sign and the sum's sign differs.
  - sub: set when the operand signs differ and the result's sign differs from data1's.
  - All other opcodes: 0.
- State machine, states IDLE, MUL:
  - IDLE, accept of a non-mul op: the result is computed combinationally and registered at the same edge; out_valid=1 afterwards.
  - IDLE, accept of mul: go to MUL. Load the multiplicand, the multiplier and a counter of WIDTH. Clear the accumulator.
  - MUL: one shift-add step per cycle; the counter decrements.
  - MUL, when the counter reaches 0: load result=accumulator, set out_valid=1, return to IDLE.
- in_ready = !rst & (state==IDLE) & (!out_valid | out_ready).
  - A new op may be accepted in the same cycle the previous result is taken: back-to-back throughput of 1 op/cycle for single-cycle ops.
- Output holding:
  - While out_valid=1 and out_ready=0, result and overflow hold stable.
  - The holding rule also applies when a multiply finishes: it cannot complete until the output register is free. MUL holds its final count with busy=1.
- busy = (state==MUL).
- out_valid clears on handoff unless a new result is loaded at the same edge.

## Timing
- Reset: while rst is high at an edge:
  - state=IDLE, out_valid=0, result=0, overflow=0, busy=0.
  - in_ready=0 during any cycle rst is asserted.
- Single-cycle ops: accept at edge N; out_valid=1 and result valid after edge N.
- mul: accept at edge N; busy=1 from N to N+WIDTH-1; out_valid=1 after edge N+WIDTH, if the output register was free.
- in_valid with in_ready=0: the op is not captured; the source must hold it.
- Reset mid-multiply: the op is aborted, no result is produced, and the block returns to IDLE after that edge.
- Shift amounts use only the low SHW bits of data1; upper bits are ignored.
- Opcode decode is from the captured aluop only. Changes on the aluop/data inputs after the accept edge have no effect.

## Test plan
- Add overflow: WIDTH=32, add 0x7FFFFFFF+0x00000001 → result 0x80000000, overflow 1, out_valid one cycle after accept.
- Signed compare under overflow: slt data1=0x80000000, data2=0x00000001 → result 1. The same operands with sltu → result 0.
- Shifts: data2=0x80000000, data1=0x24:
  - sra → 0xF8000000 (only the low 5 bits of data1 are used, so the shift is 4).
  - srl → 0x08000000.
- Multiply: mul 7×6 → result 0x2A; busy=1 for 32 cycles; out_valid after edge N+32; in_ready=0 throughout.
  - mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- Backpressure: out_ready=0 with 3 back-to-back ops offered:
  - First result holds stable and in_ready=0.
  - After out_ready rises, the ops complete one per cycle, in order, with none lost.
- Reset mid-mul: assert rst 10 cycles into a mul:
  - out_valid stays 0, result=0 and busy=0 after the edge.
  - A following add 2+3 returns 5.
